// File: rtl/bpb_history.sv
// Branch-predictor global history tracker: speculative/committed history, in-flight count, table index.
// Optional feature macro: BPB_GSHARE_EN (gshare XOR indexing; bimodal PC indexing when undefined).
`ifndef BPB_T
`define BPB_T 4
`endif

module bpb_history #(
    parameter int INDEX_WIDTH  = `BPB_T,
    parameter int HIST_WIDTH   = `BPB_T,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            en_i,
    input  logic [31:0]                     pc_i,
    input  logic                            predict_valid_i,
    input  logic                            predict_taken_i,
    output logic                            predict_ready_o,
    input  logic                            resolve_valid_i,
    input  logic                            resolve_taken_i,
    input  logic                            mispredict_i,
    output logic [INDEX_WIDTH-1:0]          index_o,
    output logic [HIST_WIDTH-1:0]           spec_hist_o,
    output logic [HIST_WIDTH-1:0]           arch_hist_o,
    output logic [$clog2(MAX_INFLIGHT):0]   inflight_o,
    output logic                            err_o
);

    localparam int CW = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

    logic [HIST_WIDTH-1:0] spec_hist_r;
    logic [HIST_WIDTH-1:0] arch_hist_r;
    logic [CW-1:0]         inflight_r;
    logic                  err_r;

    logic                  accept_s;
    logic                  res_ok_s;
    logic                  res_orphan_s;
    logic [HIST_WIDTH-1:0] arch_next_s;
    logic [HIST_WIDTH-1:0] spec_next_s;

    // Handshake qualification and next-history values.
    always_comb begin
        predict_ready_o = en_i && (inflight_r < MAX_CNT) && !(resolve_valid_i && mispredict_i);
        accept_s        = predict_valid_i && predict_ready_o;
        res_ok_s        = en_i && resolve_valid_i && (inflight_r != {CW{1'b0}});
        res_orphan_s    = en_i && resolve_valid_i && (inflight_r == {CW{1'b0}});
        arch_next_s     = {arch_hist_r[HIST_WIDTH-2:0], resolve_taken_i};
        spec_next_s     = {spec_hist_r[HIST_WIDTH-2:0], predict_taken_i};
    end

    // Table index uses the pre-edge speculative history.
`ifdef BPB_GSHARE_EN
    always_comb begin
        index_o = pc_i[INDEX_WIDTH+1:2] ^ spec_hist_r;
    end
    logic unused_pc_s;
    assign unused_pc_s = ^{pc_i[31:INDEX_WIDTH+2], pc_i[1:0]};
`else
    always_comb begin
        index_o = pc_i[INDEX_WIDTH+1:2];
    end
    logic unused_pc_s;
    assign unused_pc_s = ^{pc_i[31:INDEX_WIDTH+2], pc_i[1:0]};
`endif

    // History, occupancy and sticky error state; a mispredict rewinds speculation to committed history.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            spec_hist_r <= {HIST_WIDTH{1'b0}};
            arch_hist_r <= {HIST_WIDTH{1'b0}};
            inflight_r  <= {CW{1'b0}};
            err_r       <= 1'b0;
        end else if (res_ok_s && mispredict_i) begin
            arch_hist_r <= arch_next_s;
            spec_hist_r <= arch_next_s;
            inflight_r  <= {CW{1'b0}};
        end else begin
            if (res_ok_s) begin
                arch_hist_r <= arch_next_s;
            end
            if (accept_s) begin
                spec_hist_r <= spec_next_s;
            end
            if (res_orphan_s) begin
                err_r <= 1'b1;
            end
            case ({accept_s, res_ok_s})
                2'b10:   inflight_r <= inflight_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   inflight_r <= inflight_r - {{(CW-1){1'b0}}, 1'b1};
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    assign spec_hist_o = spec_hist_r;
    assign arch_hist_o = arch_hist_r;
    assign inflight_o  = inflight_r;
    assign err_o       = err_r;

endmodule

// File: tb/tb_bpb_history.sv
// Directed bench for bpb_history (4-bit history, 4 in flight); index expectation follows BPB_GSHARE_EN.
module tb_bpb_history;

    logic        clk_i = 1'b0;
    logic        rst_ni, en_i;
    logic [31:0] pc_i;
    logic        predict_valid_i, predict_taken_i, predict_ready_o;
    logic        resolve_valid_i, resolve_taken_i, mispredict_i;
    logic [3:0]  index_o, spec_hist_o, arch_hist_o;
    logic [2:0]  inflight_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;

    bpb_history #(.INDEX_WIDTH(4), .HIST_WIDTH(4), .MAX_INFLIGHT(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .pc_i(pc_i),
        .predict_valid_i(predict_valid_i), .predict_taken_i(predict_taken_i),
        .predict_ready_o(predict_ready_o), .resolve_valid_i(resolve_valid_i),
        .resolve_taken_i(resolve_taken_i), .mispredict_i(mispredict_i),
        .index_o(index_o), .spec_hist_o(spec_hist_o), .arch_hist_o(arch_hist_o),
        .inflight_o(inflight_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic pv, input logic pt, input logic rv, input logic rt, input logic mp);
        predict_valid_i = pv; predict_taken_i = pt;
        resolve_valid_i = rv; resolve_taken_i = rt; mispredict_i = mp;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic state(input string tag, input logic [3:0] sh, input logic [3:0] ah,
                         input logic [2:0] inf, input logic er);
        check({tag, ".spec"}, 32'(spec_hist_o), 32'(sh));
        check({tag, ".arch"}, 32'(arch_hist_o), 32'(ah));
        check({tag, ".infl"}, 32'(inflight_o), 32'(inf));
        check({tag, ".err"},  32'(err_o), 32'(er));
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst_ni = 1'b1;
    endtask

    logic [3:0] exp_idx;

    initial begin
        rst_ni = 1'b0; en_i = 1'b1; pc_i = 32'h0000_0014;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); step();
        rst_ni = 1'b1;
        #1;
        state("reset", 4'b0000, 4'b0000, 3'd0, 1'b0);
        check("reset.ready", 32'(predict_ready_o), 32'd1);

        // T,T,N accepts
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        state("ttn", 4'b0110, 4'b0000, 3'd3, 1'b0);
`ifdef BPB_GSHARE_EN
        exp_idx = 4'b0011;
`else
        exp_idx = 4'b0101;
`endif
        check("ttn.index", 32'(index_o), 32'(exp_idx));

        // fill to MAX, then an ignored fifth predict
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step();
        check("full.ready", 32'(predict_ready_o), 32'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        state("full", 4'b1101, 4'b0000, 3'd4, 1'b0);
        pc_i = 32'h0000_0000; #1;
`ifdef BPB_GSHARE_EN
        exp_idx = 4'b1101;
`else
        exp_idx = 4'b0000;
`endif
        check("full.index", 32'(index_o), 32'(exp_idx));

        // simultaneous accept + plain resolve keeps count
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step();
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        state("both", 4'b0001, 4'b0001, 3'd2, 1'b0);

        // mispredict with competing predict
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1); #1;
        check("misp.ready", 32'(predict_ready_o), 32'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        state("misp", 4'b0011, 4'b0011, 3'd0, 1'b0);

        // orphan resolve alongside an accept
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        state("orphan", 4'b0111, 4'b0011, 3'd1, 1'b1);
        step();
        check("orphan.sticky", 32'(err_o), 32'd1);

        // freeze with en low, then reset with en low
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step();
        en_i = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); #1;
        check("hold.ready", 32'(predict_ready_o), 32'd0);
        step(); step();
        state("hold", 4'b1110, 4'b0011, 3'd2, 1'b1);
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
        state("rst2", 4'b0000, 4'b0000, 3'd0, 1'b0);
        en_i = 1'b1; #1;
        check("rst2.ready", 32'(predict_ready_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bpb_history.md
BPB_HISTORY -- requirements
Module: bpb_history

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default `BPB_T: width of the pattern-table index produced.
REQ-002 SHALL have parameter HIST_WIDTH, default `BPB_T: global history length; SHALL equal INDEX_WIDTH when BPB_GSHARE_EN is defined.
REQ-003 SHALL have parameter MAX_INFLIGHT, default 4: maximum unresolved predictions; power of two, >= 2.
REQ-004 SHALL have port clk_i, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port en_i, input, 1: pipeline enable; low freezes all state.
REQ-007 SHALL have port pc_i, input, 32: fetch PC of the branch being predicted.
REQ-008 SHALL have port predict_valid_i, input, 1: a prediction is issued this cycle.
REQ-009 SHALL have port predict_taken_i, input, 1: predicted direction (pattern-table state MSB).
REQ-010 SHALL have port predict_ready_o, output, 1: prediction can be accepted this cycle.
REQ-011 SHALL have port resolve_valid_i, input, 1: oldest in-flight branch resolved.
REQ-012 SHALL have port resolve_taken_i, input, 1: actual direction of the resolved branch.
REQ-013 SHALL have port mispredict_i, input, 1: resolved branch was mispredicted; qualified by resolve_valid_i.
REQ-014 SHALL have port index_o, output, INDEX_WIDTH: pattern-table index, driven to the BHT index_i.
REQ-015 SHALL have ports spec_hist_o and arch_hist_o, output, HIST_WIDTH each: speculative and committed history.
REQ-016 SHALL have port inflight_o, output, $clog2(MAX_INFLIGHT)+1: count of unresolved predictions.
REQ-017 SHALL have port err_o, output, 1: sticky flag for a resolve received with no prediction in flight.

Function
REQ-018 predict_ready_o SHALL be en_i && (inflight < MAX_INFLIGHT) && !(resolve_valid_i && mispredict_i), combinational.
REQ-019 A prediction SHALL be accepted when predict_valid_i && predict_ready_o; accept: spec_hist <= {spec_hist[HIST_WIDTH-2:0], predict_taken_i}, inflight +1.
REQ-020 A resolve SHALL be valid only when en_i && resolve_valid_i && inflight != 0.
REQ-021 A valid resolve SHALL set arch_hist <= {arch_hist[HIST_WIDTH-2:0], resolve_taken_i} and decrement inflight by 1.
REQ-022 A valid resolve with mispredict_i SHALL also set spec_hist to the new arch_hist value and inflight to 0, in the same edge.
REQ-023 Accept and non-mispredict resolve in the same cycle SHALL apply both shifts and leave inflight unchanged.
REQ-024 resolve_valid_i with inflight == 0 and en_i high SHALL change no history or count and SHALL set err_o, even if a prediction is accepted that cycle.
REQ-025 inflight SHALL never exceed MAX_INFLIGHT nor wrap below 0.
REQ-026 index_o SHALL be combinational from pc_i and the current (pre-edge) spec_hist; pc bits used are pc_i[INDEX_WIDTH+1:2].
REQ-027 When en_i is low, no register SHALL change; outputs SHALL reflect held state.

Reset
REQ-028 On rising clk_i edge with rst_ni low: spec_hist = 0, arch_hist = 0, inflight = 0, err_o = 0; reset overrides en_i and all inputs.
REQ-029 Reset mid-operation SHALL discard all in-flight predictions; predict_ready_o SHALL be high on the first cycle after reset when en_i is high.

Configuration
REQ-030 Macro BPB_GSHARE_EN defined: index_o = pc_i[INDEX_WIDTH+1:2] XOR spec_hist.
REQ-031 Macro BPB_GSHARE_EN undefined: index_o = pc_i[INDEX_WIDTH+1:2] (bimodal); history tracking, handshake and counters SHALL be unchanged.

Verification (INDEX_WIDTH = HIST_WIDTH = 4, MAX_INFLIGHT = 4, BPB_GSHARE_EN defined)
REQ-032 Reset, then accept taken predictions T,T,N -> spec_hist 4'b0110, arch_hist 0, inflight 3; pc_i 0x0000_0014 -> index_o 4'b0011.
REQ-033 Four accepts without resolve -> inflight 4, predict_ready_o 0; fifth predict_valid_i ignored, spec_hist unchanged.
REQ-034 inflight 2, arch_hist 4'b0001, resolve taken with mispredict plus predict_valid_i in the same cycle -> arch_hist 4'b0011, spec_hist 4'b0011, inflight 0, prediction not accepted.
REQ-035 inflight 0, resolve_valid_i with predict accept in the same cycle -> err_o 1 and stays 1; arch_hist unchanged; inflight 1.
REQ-036 inflight 2, en_i low with predict and resolve asserted -> all state held, predict_ready_o 0; then rst_ni low for one cycle -> all state 0.
